// File: rtl/periph_ctrl_sequencer.sv
// Transaction sequencer between the shared control register and an SPI/UART engine.
// Optional macro PERIPH_TIMEOUT_EN enables the WAIT timeout and ERR reporting.
`timescale 1ns/1ps

module periph_ctrl_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      ctrl_i,
  input  logic             cpu_wr_i,
  output logic             wr_o,
  output logic [31:0]      data_o,
  output logic             start_o,
  input  logic             done_i,
  input  logic             rx_valid_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] txn_cnt_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("periph_ctrl_sequencer: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_WB} state_e;

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             rx_seen_q, rx_seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_issue;
  logic             err_bit;

`ifdef PERIPH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Timeout fires on the WAIT cycle whose increment would reach TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  assign err_bit = err_q;
`else
  assign err_bit = ctrl_i[2];
`endif

  // The collision check has to see the CPU strobe of the same cycle, otherwise
  // both ports would land on the register at one edge and CPU data could be lost.
  assign wr_issue  = (state_q == S_WB) && !cpu_wr_i;
  assign wr_o      = wr_issue;
  assign data_o    = wr_issue ? {ctrl_i[31:3], err_bit, ctrl_i[1] | rx_seen_q, 1'b0} : 32'h0;
  assign start_o   = start_q;
  assign busy_o    = busy_q;
  assign txn_cnt_o = cnt_q;

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    rx_seen_d = rx_seen_q;
    cnt_d     = cnt_q;
`ifdef PERIPH_TIMEOUT_EN
    timer_d   = timer_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ctrl_i[0]) begin
          state_d = S_START;
          start_d = 1'b1;
        end
      end
      S_START: begin
        state_d   = S_WAIT;
        rx_seen_d = 1'b0;
`ifdef PERIPH_TIMEOUT_EN
        timer_d   = '0;
        err_d     = 1'b0;
`endif
      end
      S_WAIT: begin
        if (rx_valid_i) begin
          rx_seen_d = 1'b1;
        end
        if (done_i) begin
          state_d = S_WB;
`ifdef PERIPH_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_WB;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
`endif
        end
      end
      S_WB: begin
        if (!cpu_wr_i) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      rx_seen_q <= 1'b0;
      cnt_q     <= '0;
`ifdef PERIPH_TIMEOUT_EN
      timer_q   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      rx_seen_q <= rx_seen_d;
      cnt_q     <= cnt_d;
`ifdef PERIPH_TIMEOUT_EN
      timer_q   <= timer_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_periph_ctrl_sequencer.sv
// Scoreboard bench for periph_ctrl_sequencer: a control-register model feeds ctrl_i,
// a spec-level model predicts each write-back, and a monitor checks every write.
`timescale 1ns/1ps

module tb_periph_ctrl_sequencer;

  localparam int T     = 16;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      ctrl_reg = 32'h0;
  logic [31:0]      cpu_data = 32'h0;
  logic             cpu_wr = 1'b0;
  logic             done = 1'b0;
  logic             rx = 1'b0;
  logic             wr_o;
  logic [31:0]      data_o;
  logic             start_o;
  logic             busy_o;
  logic [CNT_W-1:0] txn_cnt_o;

  typedef struct {
    logic [31:0] data;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_cnt = 0;
  int   start_exp = 0;
  int   start_seen = 0;

  periph_ctrl_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CNT_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ctrl_i    (ctrl_reg),
    .cpu_wr_i  (cpu_wr),
    .wr_o      (wr_o),
    .data_o    (data_o),
    .start_o   (start_o),
    .done_i    (done),
    .rx_valid_i(rx),
    .busy_o    (busy_o),
    .txn_cnt_o (txn_cnt_o)
  );

  always #5 clk = ~clk;

  // Control register: CPU port has priority, the sequencer uses the secondary port.
  always @(posedge clk) begin
    if (cpu_wr) ctrl_reg <= cpu_data;
    else if (wr_o) ctrl_reg <= data_o;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (start_o) begin
        start_seen++;
        checkOutput("start_wr_exclusive", {31'b0, wr_o}, 32'h0);
      end
      if (wr_o) begin
        checkOutput("wr_no_collision", {31'b0, cpu_wr}, 32'h0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", {31'b0, wr_o}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("wb_data", data_o, e.data);
          checkOutput("cnt_before_wb", {{(32-CNT_W){1'b0}}, txn_cnt_o}, 32'(e.cnt % (1 << CNT_W)));
        end
      end
    end
  end

  // One full transaction: k = WAIT cycle carrying done (1-based), r = cycle carrying
  // rx_valid (0 = START cycle), c = CPU collision cycles starting at the write-back cycle.
  task automatic applyStimulus(input logic [31:0] init_val, input int k, input int r,
                               input int c, input logic [28:0] new_upper);
    int          j_exit;
    logic        err;
    logic        rx_seen;
    logic [28:0] upper;
    exp_t        e;
`ifdef PERIPH_TIMEOUT_EN
    j_exit = (k < T - 1) ? k : T - 1;
    err    = (k > T - 1);
`else
    j_exit = k;
    err    = init_val[2];
`endif
    rx_seen = (r >= 1) && (r <= j_exit);
    upper   = (c > 0) ? new_upper : init_val[31:3];
    e.data  = {upper, err, init_val[1] | rx_seen, 1'b0};
    e.cnt   = model_cnt;
    exp_q.push_back(e);
    model_cnt++;
    start_exp++;

    @(negedge clk); cpu_wr = 1'b1; cpu_data = init_val | 32'h1;
    @(negedge clk); cpu_wr = 1'b0;
    for (int j = 0; j <= j_exit; j++) begin
      @(negedge clk); done = (j == k); rx = (j == r);
      #1;
      if (j == 0) checkOutput("start_pulse", {31'b0, start_o}, 32'h1);
      checkOutput("no_early_wr", {31'b0, wr_o}, 32'h0);
    end
    for (int i = 0; i < c; i++) begin
      @(negedge clk);
      done = (i == 0) && (k == j_exit + 1);
      rx   = (i == 0) && (r == j_exit + 1);
      cpu_wr = 1'b1; cpu_data = {new_upper, ctrl_reg[2:0]};
      #1;
      checkOutput("wr_held", {31'b0, wr_o}, 32'h0);
    end
    @(negedge clk);
    done = (c == 0) && (k == j_exit + 1);
    rx   = (c == 0) && (r == j_exit + 1);
    cpu_wr = 1'b0;
    #1;
    checkOutput("wr_issue", {31'b0, wr_o}, 32'h1);
    @(negedge clk); done = 1'b0; rx = 1'b0;
    #1;
    checkOutput("busy_after", {31'b0, busy_o}, 32'h0);
    checkOutput("send_cleared", {31'b0, ctrl_reg[0]}, 32'h0);
  endtask

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    #1;
    checkOutput("reset_wr", {31'b0, wr_o}, 32'h0);
    checkOutput("reset_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("reset_cnt", {{(32-CNT_W){1'b0}}, txn_cnt_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(32'h0000_0001, 5, 99, 0, 29'h0);
    applyStimulus(32'hA500_0001, 4, 2, 0, 29'h0);
`ifdef PERIPH_TIMEOUT_EN
    applyStimulus(32'h0000_0001, 20, 99, 0, 29'h0);
`else
    applyStimulus(32'h0000_0001, 100, 99, 0, 29'h0);
`endif
    applyStimulus(32'h0000_0001, 3, 99, 2, 29'(32'h0000_0F01 >> 3));
    applyStimulus(32'h0000_0001, T - 1, T - 1, 0, 29'h0);
    applyStimulus(32'h0000_0001, T, 0, 1, 29'h1234);

    for (int n = 0; n < 20; n++) begin
      v = $urandom;
      applyStimulus(v, $urandom_range(1, T + 2), $urandom_range(0, T + 2),
                    $urandom_range(0, 2), 29'($urandom));
    end

    // Reset in the middle of WAIT: no write-back, counter cleared, register cleared by CPU.
    @(negedge clk); cpu_wr = 1'b1; cpu_data = 32'h0000_0001;
    @(negedge clk); cpu_wr = 1'b0;
    start_exp++;
    repeat (3) @(negedge clk);
    #1; rst = 1'b1; cpu_wr = 1'b1; cpu_data = 32'h0;
    #1;
    checkOutput("midrst_wr", {31'b0, wr_o}, 32'h0);
    checkOutput("midrst_start", {31'b0, start_o}, 32'h0);
    checkOutput("midrst_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("midrst_data", data_o, 32'h0);
    checkOutput("midrst_cnt", {{(32-CNT_W){1'b0}}, txn_cnt_o}, 32'h0);
    model_cnt = 0;
    @(negedge clk); rst = 1'b0; cpu_wr = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("idle_after_rst", {31'b0, busy_o}, 32'h0);
    applyStimulus(32'h0000_0003, 2, 1, 0, 29'h0);

    repeat (3) @(negedge clk);
    checkOutput("start_count", 32'(start_seen), 32'(start_exp));
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
